bank_rejestrow: RTL and testbench

General-purpose register bank of the PLC core: eight 8-bit working registers with a single write port that performs load, clear, increment, decrement, shift and two-cycle swap operations, and maintains zero/carry flags. All eight register contents are presented in parallel on `reg0`..`reg7`, which connect directly to the `in0`..`in7` inputs of the downstream 8:1 register read multiplexer. The block is the storage and write-back stage that feeds that read path.

---
 rtl/bank_rejestrow_pkg.sv | 24 ++
 rtl/bank_rejestrow_if.sv | 28 ++
 rtl/bank_rejestrow_alu.sv | 48 ++++
 rtl/bank_rejestrow.sv | 115 +++++++++++
 tb/tb_bank_rejestrow.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/bank_rejestrow_pkg.sv
// Shared definitions for the PLC register bank: opcodes, FSM states and
// default geometry.
package pkg_rejestr;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_NREG  = 8;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_LOAD = 3'b001,
      OP_CLR  = 3'b010,
      OP_INC  = 3'b011,
      OP_DEC  = 3'b100,
      OP_SHL  = 3'b101,
      OP_SHR  = 3'b110,
      OP_SWAP = 3'b111
   } op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWAP2 = 1'b1
   } state_t;

endpackage

// File: rtl/bank_rejestrow_if.sv
// Write-port request and parallel register/flag outputs of the register bank.
interface bank_rejestrow_if
   import pkg_rejestr::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             wr_en;
   logic [2:0]       wr_sel;
   logic [2:0]       wr_op;
   logic [WIDTH-1:0] wr_data;

   logic [WIDTH-1:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
   logic             flag_z;
   logic             flag_c;
   logic             busy;

   modport master (
      output wr_en, wr_sel, wr_op, wr_data,
      input  reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
      input  flag_z, flag_c, busy
   );

   modport slave (
      input  wr_en, wr_sel, wr_op, wr_data,
      output reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7,
      output flag_z, flag_c, busy
   );
endinterface

// File: rtl/bank_rejestrow_alu.sv
// Combinational single-operand ALU: result plus zero and carry/borrow/shift-out.
// Also used by the accumulator stage, so it has no knowledge of the register bank.
module alu_rejestr
   import pkg_rejestr::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] operand,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             c
);
   logic [WIDTH:0] wide;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      wide   = '0;
      result = operand;
      c      = 1'b0;
      case (op)
         OP_LOAD: result = data;
         OP_CLR:  result = '0;
         OP_INC: begin
            wide   = {1'b0, operand} + {{WIDTH{1'b0}}, 1'b1};
            result = wide[WIDTH-1:0];
            c      = wide[WIDTH];
         end
         OP_DEC: begin
            // The extra top bit becomes 1 only when 0 is decremented past zero.
            wide   = {1'b0, operand} - {{WIDTH{1'b0}}, 1'b1};
            result = wide[WIDTH-1:0];
            c      = wide[WIDTH];
         end
         OP_SHL: begin
            result = {operand[WIDTH-2:0], 1'b0};
            c      = operand[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, operand[WIDTH-1:1]};
            c      = operand[0];
         end
         default: result = operand;
      endcase
      z = (result == '0);
   end
endmodule

// File: rtl/bank_rejestrow.sv
// Eight-entry working register bank with a single write port, zero/carry flags
// and a two-cycle SWAP sequenced by a small FSM.
module bank_rejestrow
   import pkg_rejestr::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   bank_rejestrow_if.slave   bus
);
   localparam int NREG = DEF_NREG;

   logic [WIDTH-1:0] regs [NREG];
   state_t           state, state_next;
   logic [WIDTH-1:0] tmp;
   logic [2:0]       b_q;
   logic             flag_z, flag_c;

   op_t              op;
   logic [2:0]       b_sel;
   logic [WIDTH-1:0] alu_result;
   logic             alu_z, alu_c;

   logic             wr_we, flag_we, tmp_we, b_we;
   logic [2:0]       wr_addr;
   logic [WIDTH-1:0] wr_val;

   assign op    = op_t'(bus.wr_op);
   assign b_sel = bus.wr_data[2:0];

   alu_rejestr #(.WIDTH(WIDTH)) u_alu (
      .op      (op),
      .operand (regs[bus.wr_sel]),
      .data    (bus.wr_data),
      .result  (alu_result),
      .z       (alu_z),
      .c       (alu_c)
   );

   // Single write port: at most one register is written per cycle, either the
   // ALU result, the first half of a SWAP, or the deferred second half from tmp.
   always_comb begin
      state_next = state;
      wr_we      = 1'b0;
      wr_addr    = bus.wr_sel;
      wr_val     = alu_result;
      flag_we    = 1'b0;
      tmp_we     = 1'b0;
      b_we       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.wr_en) begin
               if (op == OP_SWAP) begin
                  wr_we      = 1'b1;
                  wr_val     = regs[b_sel];
                  tmp_we     = 1'b1;
                  b_we       = 1'b1;
                  state_next = ST_SWAP2;
               end else if (op != OP_NOP) begin
                  wr_we   = 1'b1;
                  flag_we = 1'b1;
               end
            end
         end
         ST_SWAP2: begin
            wr_we      = 1'b1;
            wr_addr    = b_q;
            wr_val     = tmp;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is small and must read as zero straight after reset, so it is reset like any other flop rather than left as an uninitialised RAM.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_we) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         regs[wr_addr] <= wr_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         tmp    <= '0;
         b_q    <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         state <= state_next;
         if (tmp_we)  tmp <= regs[bus.wr_sel];
         if (b_we)    b_q <= b_sel;
         if (flag_we) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
         end
      end
   end

   assign bus.reg0   = regs[0];
   assign bus.reg1   = regs[1];
   assign bus.reg2   = regs[2];
   assign bus.reg3   = regs[3];
   assign bus.reg4   = regs[4];
   assign bus.reg5   = regs[5];
   assign bus.reg6   = regs[6];
   assign bus.reg7   = regs[7];
   assign bus.flag_z = flag_z;
   assign bus.flag_c = flag_c;
   assign bus.busy   = (state == ST_SWAP2);
endmodule

// File: tb/tb_bank_rejestrow.sv
// Directed self-checking bench for bank_rejestrow: reset, arithmetic wrap,
// shifts, SWAP with a dropped request, reset mid-SWAP and back-to-back loads.
module tb_bank_rejestrow;
   import pkg_rejestr::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bank_rejestrow_if #(.WIDTH(8)) bus ();

   bank_rejestrow #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_reg(input int i);
      case (i)
         0: return bus.reg0;
         1: return bus.reg1;
         2: return bus.reg2;
         3: return bus.reg3;
         4: return bus.reg4;
         5: return bus.reg5;
         6: return bus.reg6;
         default: return bus.reg7;
      endcase
   endfunction

   // Drives one request at the falling edge, then returns at the next falling
   // edge, so the rising edge in between has sampled it.
   task automatic step(input logic en, input logic [2:0] sel, input op_t op, input logic [7:0] data);
      bus.wr_en   = en;
      bus.wr_sel  = sel;
      bus.wr_op   = op;
      bus.wr_data = data;
      @(negedge clk);
   endtask

   task automatic check_flags(input string tag, input logic z, input logic c);
      check({tag, "_z"}, {31'd0, bus.flag_z}, {31'd0, z});
      check({tag, "_c"}, {31'd0, bus.flag_c}, {31'd0, c});
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_r%0d", tag, i), {24'd0, get_reg(i)}, 32'h0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_sel  = 3'd0;
      bus.wr_op   = OP_NOP;
      bus.wr_data = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state after power-on.
      check_all_zero("por");
      check_flags("por", 1'b0, 1'b0);
      check("por_busy", {31'd0, bus.busy}, 32'h0);

      // Preload nonzero values and set both flags, then reset between edges.
      step(1'b1, 3'd0, OP_LOAD, 8'hA5);
      step(1'b1, 3'd7, OP_LOAD, 8'h3C);
      step(1'b1, 3'd4, OP_LOAD, 8'hFF);
      step(1'b1, 3'd4, OP_INC,  8'h00);
      check("pre_r0", {24'd0, bus.reg0}, 32'hA5);
      check("pre_r7", {24'd0, bus.reg7}, 32'h3C);
      check("pre_r4", {24'd0, bus.reg4}, 32'h00);
      check_flags("pre", 1'b1, 1'b1);
      bus.wr_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("arst");
      check_flags("arst", 1'b0, 1'b0);
      check("arst_busy", {31'd0, bus.busy}, 32'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);

      // LOAD / INC wrap.
      step(1'b1, 3'd3, OP_LOAD, 8'hFE);
      check("ld_r3", {24'd0, bus.reg3}, 32'hFE);
      check_flags("ld", 1'b0, 1'b0);
      step(1'b1, 3'd3, OP_INC, 8'h00);
      check("inc1_r3", {24'd0, bus.reg3}, 32'hFF);
      check_flags("inc1", 1'b0, 1'b0);
      step(1'b1, 3'd3, OP_INC, 8'h00);
      check("inc2_r3", {24'd0, bus.reg3}, 32'h00);
      check_flags("inc2", 1'b1, 1'b1);

      // DEC borrow and shifts.
      step(1'b1, 3'd5, OP_LOAD, 8'h00);
      check_flags("ld0", 1'b1, 1'b0);
      step(1'b1, 3'd5, OP_DEC, 8'h00);
      check("dec_r5", {24'd0, bus.reg5}, 32'hFF);
      check_flags("dec", 1'b0, 1'b1);
      step(1'b1, 3'd5, OP_SHL, 8'h00);
      check("shl_r5", {24'd0, bus.reg5}, 32'hFE);
      check_flags("shl", 1'b0, 1'b1);
      step(1'b1, 3'd5, OP_LOAD, 8'h01);
      step(1'b1, 3'd5, OP_SHR, 8'h00);
      check("shr_r5", {24'd0, bus.reg5}, 32'h00);
      check_flags("shr", 1'b1, 1'b1);
      step(1'b1, 3'd2, OP_LOAD, 8'h81);
      step(1'b1, 3'd2, OP_SHR, 8'h00);
      check("shr2_r2", {24'd0, bus.reg2}, 32'h40);
      check_flags("shr2", 1'b0, 1'b1);
      step(1'b1, 3'd2, OP_CLR, 8'h00);
      check("clr_r2", {24'd0, bus.reg2}, 32'h00);
      check_flags("clr", 1'b1, 1'b0);

      // SWAP r1/r6 with a LOAD presented during the busy cycle.
      step(1'b1, 3'd1, OP_LOAD, 8'h11);
      step(1'b1, 3'd6, OP_LOAD, 8'h66);
      step(1'b1, 3'd4, OP_LOAD, 8'hFF);
      step(1'b1, 3'd4, OP_INC,  8'h00);
      check_flags("preswap", 1'b1, 1'b1);
      step(1'b1, 3'd1, OP_SWAP, 8'h06);
      check("swN_r1", {24'd0, bus.reg1}, 32'h66);
      check("swN_r6", {24'd0, bus.reg6}, 32'h66);
      check("swN_busy", {31'd0, bus.busy}, 32'h1);
      check_flags("swN", 1'b1, 1'b1);
      step(1'b1, 3'd1, OP_LOAD, 8'h99);
      check("swN1_r6", {24'd0, bus.reg6}, 32'h11);
      check("swN1_r1", {24'd0, bus.reg1}, 32'h66);
      check("swN1_busy", {31'd0, bus.busy}, 32'h0);
      check_flags("swN1", 1'b1, 1'b1);
      step(1'b0, 3'd0, OP_NOP, 8'h00);
      check("swdrop_r1", {24'd0, bus.reg1}, 32'h66);

      // SWAP with A == B.
      step(1'b1, 3'd3, OP_LOAD, 8'h42);
      step(1'b1, 3'd3, OP_SWAP, 8'h03);
      check("swaa_busy", {31'd0, bus.busy}, 32'h1);
      check("swaa_r3a", {24'd0, bus.reg3}, 32'h42);
      step(1'b0, 3'd0, OP_NOP, 8'h00);
      check("swaa_idle", {31'd0, bus.busy}, 32'h0);
      check("swaa_r3b", {24'd0, bus.reg3}, 32'h42);

      // Reset in the middle of a SWAP.
      step(1'b1, 3'd1, OP_SWAP, 8'h06);
      check("mid_busy1", {31'd0, bus.busy}, 32'h1);
      bus.wr_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("mid");
      check("mid_busy0", {31'd0, bus.busy}, 32'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 3'd0, OP_LOAD, 8'h5A);
      check("mid_ld_r0", {24'd0, bus.reg0}, 32'h5A);
      check("mid_ld_r6", {24'd0, bus.reg6}, 32'h00);
      check("mid_ld_busy", {31'd0, bus.busy}, 32'h0);

      // Back-to-back loads on consecutive cycles.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 3'(i), OP_LOAD, 8'(8'h10 + i));
         check($sformatf("b2b_r%0d", i), {24'd0, get_reg(i)}, 32'(8'h10 + i));
         for (int j = i + 1; j < 8; j++)
            check($sformatf("b2b_%0d_keep_r%0d", i, j), {24'd0, get_reg(j)}, 32'h0);
      end
      step(1'b1, 3'd2, OP_NOP, 8'hFF);
      for (int i = 0; i < 8; i++)
         check($sformatf("final_r%0d", i), {24'd0, get_reg(i)}, 32'(8'h10 + i));
      check_flags("nop", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
